// File: rtl/run_sequencer.sv
// Program-level sequencer for the EnDMe core: launches a ROM program, gates the core
// while it runs, catches HALT or runaway programs, and arbitrates data_mem host/core.
module run_sequencer #(
  parameter logic [15:0] PROG0_ADDR = 16'd0,
  parameter logic [15:0] PROG1_ADDR = 16'd128,
  parameter logic [15:0] PROG2_ADDR = 16'd256,
  parameter logic [15:0] MAX_CYCLES = 16'd4000,
  parameter int          DATA_W     = 8,
  parameter int          ADDR_W     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start_req,
  input  logic [1:0]        prog_sel,
  input  logic              halt_instr,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_gnt,
  input  logic              core_wr_en,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              dmem_wr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              pc_load,
  output logic [15:0]       pc_start_addr,
  output logic              core_en,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [15:0]       cycle_count
);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DONE, ERR} state_t;

  state_t state, state_nxt;
  logic   launch_ok;
  logic   at_limit;

  assign launch_ok = start_req && (prog_sel != 2'd3);
  assign at_limit  = (cycle_count == MAX_CYCLES - 16'd1);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state         <= IDLE;
      cycle_count   <= '0;
      pc_start_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && launch_ok) begin
        unique case (prog_sel)
          2'd0:    pc_start_addr <= PROG0_ADDR;
          2'd1:    pc_start_addr <= PROG1_ADDR;
          default: pc_start_addr <= PROG2_ADDR;
        endcase
      end
      if (state == LAUNCH)
        cycle_count <= '0;
      else if (state == RUN && cycle_count != 16'hFFFF)
        cycle_count <= cycle_count + 16'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_load     = 1'b0;
    core_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    timeout_err = 1'b0;
    host_gnt    = 1'b1;
    unique case (state)
      IDLE:   if (launch_ok) state_nxt = LAUNCH;
      LAUNCH: begin
        pc_load   = 1'b1;
        busy      = 1'b1;
        host_gnt  = 1'b0;
        state_nxt = RUN;
      end
      RUN: begin
        core_en  = 1'b1;
        busy     = 1'b1;
        host_gnt = 1'b0;
        // HALT takes priority over a timeout landing on the same cycle
        if (halt_instr)    state_nxt = DONE;
        else if (at_limit) state_nxt = ERR;
      end
      DONE: begin
        done = 1'b1;
        if (!start_req) state_nxt = IDLE;
      end
      ERR: begin
        timeout_err = 1'b1;
        if (!start_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Host writes while the core owns memory are dropped, not queued
  always_comb begin
    if (host_gnt) begin
      dmem_addr  = host_addr;
      dmem_wdata = host_wdata;
      dmem_wr    = host_wr_en;
      host_rdata = dmem_rdata;
      core_rdata = '0;
    end else begin
      dmem_addr  = core_addr;
      dmem_wdata = core_wdata;
      dmem_wr    = core_wr_en & core_en;
      host_rdata = '0;
      core_rdata = dmem_rdata;
    end
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Program-level sequencer for the EnDMe processor core.
- Launches one of three ROM programs at a fixed start address.
- Enables or stalls the core while it runs, and detects HALT and runaway programs.
- Arbitrates the single-port data memory between the external host (load/readback) and the core (during a run).
- Sits between the testbench/host, instr_fetch (PC load/enable), the controller (HALT decode) and data_mem.

Parameters:
PROG0_ADDR, 16'd0, start PC of program 0
PROG1_ADDR, 16'd128, start PC of program 1
PROG2_ADDR, 16'd256, start PC of program 2
MAX_CYCLES, 16'd4000, RUN cycles allowed before timeout
DATA_W, 8, data memory word width
ADDR_W, 8, data memory address width

Ports:
CLK  in  1  clock, all state changes on rising edge
RESET  in  1  synchronous, active-low reset
start_req  in  1  host level request; a run launches when it is high in IDLE
prog_sel  in  2  program select 0..2; 3 is reserved
halt_instr  in  1  controller has decoded HALT in the current instruction
host_wr_en  in  1  host data_mem write strobe
host_addr  in  ADDR_W  host data_mem address
host_wdata  in  DATA_W  host write data
host_rdata  out  DATA_W  host read data
host_gnt  out  1  host currently owns data_mem
core_wr_en  in  1  core memwrite_ctrl
core_addr  in  ADDR_W  core address (register output)
core_wdata  in  DATA_W  core write data (accumulator)
core_rdata  out  DATA_W  data to accumulator mem input
dmem_wr  out  1  data_mem write enable
dmem_addr  out  ADDR_W  data_mem address
dmem_wdata  out  DATA_W  data_mem write data
dmem_rdata  in  DATA_W  data_mem read data
pc_load  out  1  instr_fetch loads pc_start_addr this edge
pc_start_addr  out  16  start address for pc_load
core_en  out  1  core advances PC and commits reg/acc/mem writes
busy  out  1  LAUNCH or RUN
done  out  1  run ended by HALT
timeout_err  out  1  run ended by MAX_CYCLES
cycle_count  out  16  RUN cycles in current/last run, saturating at 16'hFFFF

Behaviour:
- FSM states: IDLE, LAUNCH, RUN, DONE, ERR. Reset (RESET==0 at an edge) forces IDLE from any state, including mid-RUN.
- Reset values: state IDLE, cycle_count 0, all outputs 0 except host_gnt=1. pc_start_addr=0 and host_rdata=dmem_rdata (combinational pass-through).
- IDLE: host_gnt=1, core_en=0.
  - start_req=1 and prog_sel<3 -> LAUNCH.
  - prog_sel==3 -> stay IDLE; request ignored.
- LAUNCH (exactly 1 cycle):
  - pc_load=1, pc_start_addr=PROGn_ADDR (registered at entry), core_en=0, busy=1, host_gnt=0.
  - cycle_count cleared to 0 -> RUN.
- RUN: core_en=1, busy=1, host_gnt=0; cycle_count increments every RUN cycle.
  - halt_instr=1 -> DONE. The HALT cycle is counted; core_en drops on the next cycle.
  - Otherwise, if cycle_count==MAX_CYCLES-1 -> ERR.
  - halt_instr and timeout in the same cycle: HALT wins -> DONE.
  - start_req and prog_sel changes are ignored in RUN.
- DONE: done=1, host_gnt=1, core_en=0; cycle_count frozen. start_req==0 -> IDLE, clearing done.
- ERR: timeout_err=1, host_gnt=1, core_en=0; cycle_count frozen. start_req==0 -> IDLE.
- Mux (combinational) when host_gnt=1:
  - dmem_addr=host_addr, dmem_wdata=host_wdata, dmem_wr=host_wr_en.
  - core_rdata=0.
- Mux when host_gnt=0:
  - dmem_addr=core_addr, dmem_wdata=core_wdata, dmem_wr=core_wr_en&core_en.
  - host_rdata=0; host writes are dropped, not queued.
- Handshake: start_req is a level.
  - done/timeout_err hold until start_req falls.
  - A new run needs start_req low for at least one cycle in IDLE after DONE/ERR. Re-arm does not happen from a held start_req.
- Ownership switches take effect in the same cycle as the state register changes; no dead cycle beyond LAUNCH.

Test Plan:
- Reset: drive RESET=0 for 2 edges mid-RUN (cycle_count=37) -> next cycle state IDLE, core_en=0, host_gnt=1, cycle_count=0, done=0.
- Host load/readback: in IDLE, write 8'hA5 to addr 8'h10, then read -> host_rdata=8'hA5; core_wr_en=1 has no effect (dmem_wr follows host_wr_en only).
- Launch: prog_sel=1, start_req=1 -> LAUNCH next cycle with pc_load=1 and pc_start_addr=128; RUN the following cycle with core_en=1. halt_instr pulsed on the 10th RUN cycle -> done=1, cycle_count=10, host_gnt=1. Drop start_req -> IDLE.
- Timeout: MAX_CYCLES=20, halt_instr never asserted -> ERR after 20 RUN cycles, timeout_err=1, cycle_count=20. Same test with halt_instr on cycle 20 -> DONE, not ERR.
- Arbitration in RUN: host_wr_en=1 to addr 8'h10 with 8'h00 during RUN -> dmem_wr follows core only; afterwards addr 8'h10 still reads 8'hA5. Core write 8'h3C to 8'h20 lands.
- Reserved/no re-arm: prog_sel=3, start_req=1 -> stays IDLE. After DONE with start_req held high for 5 cycles -> remains DONE, no second launch.
